// File: rtl/hex_char_formatter.sv
// hex_char_formatter: streams a captured word as ASCII "0x<hex digits><'\n' or ' '>" over a valid/ready byte port.
// Optional macro HEX_FMT_UPPER_EN selects upper-case digits A-F.
module hex_char_formatter #(
   parameter int DATA_W         = 8,
   parameter bit SUPPRESS_ZEROS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_char,
   output logic              busy
);
   localparam int NIB = DATA_W / 4;
   localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
`ifdef HEX_FMT_UPPER_EN
   localparam logic [7:0] ALPHA_BASE = 8'h37;
`else
   localparam logic [7:0] ALPHA_BASE = 8'h57;
`endif
   typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGITS, TERM} state_t;
   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic [IW-1:0]       idx_q, idx_d, start_idx;
   logic [3:0]          nib;
   logic [7:0]          digit;
   logic                fire;
   // Last matching nibble wins, so without suppression the loop lands on NIB-1.
   always_comb begin
      start_idx = '0;
      for (int i = 0; i < NIB; i++)
         if (!SUPPRESS_ZEROS || in_data[i*4 +: 4] != 4'h0) start_idx = IW'(i);
   end
   always_comb begin
      nib       = data_q[idx_q*4 +: 4];
      digit     = nib < 4'd10 ? 8'h30 + {4'h0, nib} : ALPHA_BASE + {4'h0, nib};
      in_ready  = state_q == IDLE;
      out_valid = state_q != IDLE;
      busy      = state_q != IDLE;
      fire      = out_valid & out_ready;
      out_char  = state_q == PFX0   ? 8'h30 :
                  state_q == PFX1   ? 8'h78 :
                  state_q == DIGITS ? digit :
                  state_q == TERM   ? (last_q ? 8'h0A : 8'h20) : 8'h00;
   end
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE:
            if (in_valid) begin
               state_d = PFX0;
               data_d  = in_data;
               last_d  = in_last;
               idx_d   = start_idx;
            end
         PFX0:   state_d = fire ? PFX1 : PFX0;
         PFX1:   state_d = fire ? DIGITS : PFX1;
         DIGITS:
            if (fire) begin
               state_d = idx_q == '0 ? TERM : DIGITS;
               idx_d   = idx_q == '0 ? idx_q : idx_q - 1'b1;
            end
         TERM:   state_d = fire ? IDLE : TERM;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end
endmodule

// File: tb/tb_hex_char_formatter.sv
// tb_hex_char_formatter: table-driven scoreboard bench for an 8-bit suppressing and a 16-bit full-width formatter.
module tb_hex_char_formatter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ordy = 1'b1;
   logic        iv8 = 1'b0, il8 = 1'b0, ir8, ov8, busy8;
   logic [7:0]  id8 = '0, oc8;
   logic        iv16 = 1'b0, il16 = 1'b0, ir16, ov16, busy16;
   logic [15:0] id16 = '0;
   logic [7:0]  oc16;
   int          checks = 0, passed = 0;
   int          ormode = 0, cyc = 0;
   logic [3:0]  pat = 4'b1001;
   logic [7:0]  q8[$], q16[$];
   logic        st8 = 1'b0, st16 = 1'b0;
   logic [7:0]  sc8, sc16;

   typedef struct {
      bit          sel;
      logic [15:0] data;
      logic        last;
      bit          stall;
      bit          hold;
      int          n;
      logic [7:0]  exp [8];
   } vec_t;
   vec_t tbl[11];

   hex_char_formatter #(.DATA_W(8), .SUPPRESS_ZEROS(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_last(il8),
      .out_valid(ov8), .out_ready(ordy), .out_char(oc8), .busy(busy8));
   hex_char_formatter #(.DATA_W(16), .SUPPRESS_ZEROS(0)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_last(il16),
      .out_valid(ov16), .out_ready(ordy), .out_char(oc16), .busy(busy16));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] fix(input logic [7:0] c);
`ifdef HEX_FMT_UPPER_EN
      return (c >= 8'h61 && c <= 8'h66) ? c - 8'h20 : c;
`else
      return c;
`endif
   endfunction

   always @(posedge clk) begin
      #1;
      if (ormode == 1) begin
         ordy = pat[cyc % 4];
         cyc++;
      end else if (ormode == 0) ordy = 1'b1;
   end

   // Transfers are popped from the scoreboard; a stalled char must reappear unchanged.
   always @(negedge clk) begin
      if (rst) begin
         st8 = 1'b0;
         st16 = 1'b0;
      end else begin
         if (st8) chk("hold8", {ov8, oc8}, {1'b1, sc8});
         if (st16) chk("hold16", {ov16, oc16}, {1'b1, sc16});
         if (ov8 && ordy) begin
            if (q8.size() == 0) chk("extra_char8", {24'h0, oc8}, 32'hFFFF_FFFF);
            else chk("char8", oc8, q8.pop_front());
         end
         if (ov16 && ordy) begin
            if (q16.size() == 0) chk("extra_char16", {24'h0, oc16}, 32'hFFFF_FFFF);
            else chk("char16", oc16, q16.pop_front());
         end
         st8 = ov8 && !ordy;
         sc8 = oc8;
         st16 = ov16 && !ordy;
         sc16 = oc16;
      end
   end

   task automatic run_vec(input vec_t v);
      int k;
      logic r, b, o;
      ormode = v.stall ? 1 : 0;
      @(posedge clk); #1;
      if (v.sel) begin iv16 = 1'b1; id16 = v.data; il16 = v.last; end
      else begin iv8 = 1'b1; id8 = v.data[7:0]; il8 = v.last; end
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if ((v.sel ? ir16 : ir8) === 1'b1) break;
      end
      chk("accept_ready", {31'h0, v.sel ? ir16 : ir8}, 32'h1);
      for (int i = 0; i < v.n; i++)
         if (v.sel) q16.push_back(fix(v.exp[i])); else q8.push_back(fix(v.exp[i]));
      @(posedge clk); #1;
      if (!v.hold) begin
         iv8 = 1'b0; iv16 = 1'b0;
      end
      id8 = 8'($urandom); il8 = ~il8;
      id16 = 16'($urandom); il16 = ~il16;
      if (!v.stall) begin
         for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            r = v.sel ? ir16 : ir8; b = v.sel ? busy16 : busy8; o = v.sel ? ov16 : ov8;
            chk("active", {29'h0, b, o, r}, 32'h6);
         end
         @(negedge clk);
      end else begin
         for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((v.sel ? busy16 : busy8) === 1'b0) break;
            if (v.hold) chk("held_not_accepted", {31'h0, v.sel ? ir16 : ir8}, 32'h0);
         end
         chk("drain_timeout", k < 200, 32'h1);
      end
      iv8 = 1'b0; iv16 = 1'b0;
      r = v.sel ? ir16 : ir8; b = v.sel ? busy16 : busy8; o = v.sel ? ov16 : ov8;
      chk("back_idle", {29'h0, b, o, r}, 32'h1);
      chk("drained", v.sel ? q16.size() : q8.size(), 32'h0);
   endtask

   initial begin
      tbl[0]  = '{0, 16'h002D, 1, 0, 0, 5, '{8'h30, 8'h78, 8'h32, 8'h64, 8'h0A, 0, 0, 0}};
      tbl[1]  = '{0, 16'h0000, 0, 0, 0, 4, '{8'h30, 8'h78, 8'h30, 8'h20, 0, 0, 0, 0}};
      tbl[2]  = '{0, 16'h000E, 0, 0, 0, 4, '{8'h30, 8'h78, 8'h65, 8'h20, 0, 0, 0, 0}};
      tbl[3]  = '{1, 16'h00A4, 1, 0, 0, 7, '{8'h30, 8'h78, 8'h30, 8'h30, 8'h61, 8'h34, 8'h0A, 0}};
      tbl[4]  = '{0, 16'h00FA, 1, 1, 1, 5, '{8'h30, 8'h78, 8'h66, 8'h61, 8'h0A, 0, 0, 0}};
      tbl[5]  = '{0, 16'h00FF, 0, 0, 0, 5, '{8'h30, 8'h78, 8'h66, 8'h66, 8'h20, 0, 0, 0}};
      tbl[6]  = '{0, 16'h0010, 1, 0, 0, 5, '{8'h30, 8'h78, 8'h31, 8'h30, 8'h0A, 0, 0, 0}};
      tbl[7]  = '{1, 16'h0000, 0, 0, 0, 7, '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 0}};
      tbl[8]  = '{1, 16'hBEEF, 1, 1, 0, 7, '{8'h30, 8'h78, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A, 0}};
      tbl[9]  = '{0, 16'h0009, 0, 0, 0, 4, '{8'h30, 8'h78, 8'h39, 8'h20, 0, 0, 0, 0}};
      tbl[10] = '{1, 16'h7C05, 0, 0, 0, 7, '{8'h30, 8'h78, 8'h37, 8'h63, 8'h30, 8'h35, 8'h20, 0}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst8", {ir8, ov8, busy8, oc8}, {3'b100, 8'h00});
      chk("rst16", {ir16, ov16, busy16, oc16}, {3'b100, 8'h00});
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst8", {ir8, ov8, oc8}, {2'b10, 8'h00});
      for (int i = 0; i < 11; i++) run_vec(tbl[i]);
      // Reset while a digit of 8'h2D is stalled.
      ormode = 2;
      @(posedge clk); #1 ordy = 1'b1; iv8 = 1'b1; id8 = 8'h2D; il8 = 1'b1;
      q8.push_back(8'h30); q8.push_back(8'h78);
      @(posedge clk); #1 iv8 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 ordy = 1'b0;
      @(negedge clk);
      chk("stall_digit", {ov8, oc8}, {1'b1, 8'h32});
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst", {ir8, ov8, busy8, oc8}, {3'b100, 8'h00});
      chk("mid_rst_q", q8.size(), 32'h0);
      run_vec('{0, 16'h0001, 1, 0, 0, 4, '{8'h30, 8'h78, 8'h31, 8'h0A, 0, 0, 0, 0}});
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
